// File: rtl/spell_rambus_ram.sv
// Wishbone B4 classic responder: word-addressed 32-bit RAM with byte-lane writes and programmable wait states.
// Latency: request sampled at edge N, single-cycle ack during cycle N+1+WAIT_STATES.
// Backpressure: one request in flight; cyc/stb ignored in WAIT (except cyc drop = abort) and in ACK.
module spell_rambus_ram #(
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [3:0]        wb_sel_i,
    input  logic [ADDR_W-1:0] wb_addr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    output logic              wb_ack_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Counter preload: WAIT holds for WAIT_STATES cycles, the last one with cnt == 0.
    localparam logic [3:0] LP_CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;

    // Request latched at acceptance, used while waiting.
    logic              r_we;
    logic [3:0]        r_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_dat;

    logic [31:0]       r_mem [DEPTH];

    logic              w_req_we;
    logic [3:0]        w_req_sel;
    logic [ADDR_W-1:0] w_req_addr;
    logic [31:0]       w_req_dat;
    logic              w_accept;
    logic              w_enter_ack;
    logic              w_in_range;
    logic [IDX_W-1:0]  w_idx;

    // With zero wait states ACK is entered on the acceptance edge, so the
    // live bus fields must be used; otherwise the latched copy is used.
    always_comb begin
        w_accept = (r_state == ST_IDLE) && wb_cyc_i && wb_stb_i;
        if (r_state == ST_IDLE) begin
            w_req_we   = wb_we_i;
            w_req_sel  = wb_sel_i;
            w_req_addr = wb_addr_i;
            w_req_dat  = wb_dat_i;
        end else begin
            w_req_we   = r_we;
            w_req_sel  = r_sel;
            w_req_addr = r_addr;
            w_req_dat  = r_dat;
        end
        w_in_range = ({{(32-ADDR_W){1'b0}}, w_req_addr} < 32'(DEPTH));
        w_idx      = w_req_addr[IDX_W-1:0];
    end

    // Next-state and wait counter logic.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (WAIT_STATES == 0) begin
                        w_next = ST_ACK;
                    end else begin
                        w_next     = ST_WAIT;
                        w_cnt_next = LP_CNT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    w_next = ST_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next = ST_ACK;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            ST_ACK: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        w_enter_ack = (w_next == ST_ACK) && (r_state != ST_ACK);
    end

    // State register, ack pulse and read data (zero outside the ack cycle).
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            wb_ack_o <= w_enter_ack;
            if (w_enter_ack && !w_req_we && w_in_range) begin
                wb_dat_o <= r_mem[w_idx];
            end else begin
                wb_dat_o <= 32'h0;
            end
        end
    end

    // Latch the request on acceptance.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_we   <= 1'b0;
            r_sel  <= 4'h0;
            r_addr <= '0;
            r_dat  <= 32'h0;
        end else if (w_accept) begin
            r_we   <= wb_we_i;
            r_sel  <= wb_sel_i;
            r_addr <= wb_addr_i;
            r_dat  <= wb_dat_i;
        end
    end

    // RAM write on entry to ACK; contents are never reset, but a reset on
    // that edge cancels the write together with the ack.
    always_ff @(posedge clock) begin
        if (reset_n && w_enter_ack && w_req_we && w_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (w_req_sel[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_req_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_spell_rambus_ram.sv
module tb_spell_rambus_ram;

    typedef struct {
        int          dut;
        bit          rd;
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n [2];
    logic        cyc   [2];
    logic        stb   [2];
    logic        we    [2];
    logic [3:0]  sel   [2];
    logic [9:0]  addr  [2];
    logic [31:0] wdat  [2];
    logic [31:0] rdat  [2];
    logic        ack   [2];

    int          cyc_cnt = 0;
    int          checks  = 0;
    int          errors  = 0;
    bit          mon_en  = 1'b0;
    exp_t        sbq [$];
    logic [31:0] mref [2][256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    spell_rambus_ram #(.ADDR_W(10), .DEPTH(256), .WAIT_STATES(0)) u_dut0 (
        .clock(clk), .reset_n(rst_n[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]),
        .wb_we_i(we[0]), .wb_sel_i(sel[0]), .wb_addr_i(addr[0]), .wb_dat_i(wdat[0]),
        .wb_dat_o(rdat[0]), .wb_ack_o(ack[0])
    );

    spell_rambus_ram #(.ADDR_W(10), .DEPTH(256), .WAIT_STATES(3)) u_dut3 (
        .clock(clk), .reset_n(rst_n[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]),
        .wb_we_i(we[1]), .wb_sel_i(sel[1]), .wb_addr_i(addr[1]), .wb_dat_i(wdat[1]),
        .wb_dat_o(rdat[1]), .wb_ack_o(ack[1])
    );

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference memory: out-of-range writes vanish, out-of-range reads give 0.
    task automatic model_write(input int d, input logic [9:0] a, input logic [3:0] s,
                               input logic [31:0] v);
        if (a < 10'd256) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) mref[d][a[7:0]][8*b +: 8] = v[8*b +: 8];
            end
        end
    endtask

    function automatic logic [31:0] model_read(input int d, input logic [9:0] a);
        if (a < 10'd256) return mref[d][a[7:0]];
        return 32'h0;
    endfunction

    // Monitor: every check and every failure is counted here.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].due < cyc_cnt) begin
                checks++;
                errors++;
                $display("FAIL ack_missing: dut%0d no ack by cycle %0d (expected at %0d)",
                         sbq[0].dut, cyc_cnt, sbq[0].due);
                void'(sbq.pop_front());
            end
            for (int d = 0; d < 2; d++) begin
                if (ack[d] !== 1'b1) begin
                    checks++;
                    if (ack[d] !== 1'b0 || rdat[d] !== 32'h0) begin
                        errors++;
                        $display("FAIL idle_outputs: dut%0d cycle %0d ack=%b dat=%h, required ack=0 dat=00000000",
                                 d, cyc_cnt, ack[d], rdat[d]);
                    end
                end else if (sbq.size() == 0 || sbq[0].dut != d) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ack: dut%0d cycle %0d ack with no request outstanding",
                             d, cyc_cnt);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    checks++;
                    if (cyc_cnt != e.due) begin
                        errors++;
                        $display("FAIL ack_latency: dut%0d ack at cycle %0d, required %0d",
                                 d, cyc_cnt, e.due);
                    end
                    if (e.rd) begin
                        checks++;
                        if (rdat[d] !== e.dat) begin
                            errors++;
                            $display("FAIL read_data: dut%0d cycle %0d got %h, required %h",
                                     d, cyc_cnt, rdat[d], e.dat);
                        end
                    end
                end
            end
        end
    end

    // Issue one request, push its expectation, hold it until ack (bounded).
    task automatic do_req(input int d, input bit w, input logic [3:0] s, input logic [9:0] a,
                          input logic [31:0] v, input bit use_c, input logic [31:0] c);
        exp_t e;
        @(negedge clk);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; addr[d] = a; wdat[d] = v;
        e.dut = d;
        e.rd  = !w;
        e.due = cyc_cnt + 1 + ws(d);
        if (w) begin
            model_write(d, a, s, v);
            e.dat = 32'h0;
        end else begin
            e.dat = use_c ? c : model_read(d, a);
        end
        sbq.push_back(e);
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ack[d] === 1'b1) break;
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            sel[d] = 4'h0; addr[d] = 10'h0; wdat[d] = 32'h0;
        end
        @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        idle(2);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        idle(2);

        // Give every implemented word a known value.
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                do_req(d, 1'b1, 4'hF, 10'(i), $urandom, 1'b0, 32'h0);

        // Plain write then read, and byte-lane merge.
        for (int d = 0; d < 2; d++) begin
            do_req(d, 1'b1, 4'hF, 10'h005, 32'hDEADBEEF, 1'b0, 32'h0);
            do_req(d, 1'b0, 4'h3, 10'h005, 32'h0, 1'b1, 32'hDEADBEEF);
            do_req(d, 1'b1, 4'hF, 10'h007, 32'h11223344, 1'b0, 32'h0);
            do_req(d, 1'b1, 4'b0101, 10'h007, 32'hAABBCCDD, 1'b0, 32'h0);
            do_req(d, 1'b0, 4'hF, 10'h007, 32'h0, 1'b1, 32'h11BB33DD);
            // Out of range: acked, ignored, reads zero, top word untouched.
            do_req(d, 1'b1, 4'hF, 10'h0FF, 32'h0BADF00D, 1'b0, 32'h0);
            do_req(d, 1'b1, 4'hF, 10'h3FF, 32'h5A5A5A5A, 1'b0, 32'h0);
            do_req(d, 1'b0, 4'hF, 10'h3FF, 32'h0, 1'b1, 32'h0);
            do_req(d, 1'b0, 4'hF, 10'h0FF, 32'h0, 1'b1, 32'h0BADF00D);
            do_req(d, 1'b0, 4'hF, 10'h100, 32'h0, 1'b1, 32'h0);
        end

        // Abort: drop cyc one cycle into the wait; no ack, no write.
        do_req(1, 1'b1, 4'hF, 10'h010, 32'h12345678, 1'b0, 32'h0);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
        addr[1] = 10'h010; wdat[1] = 32'h00000001;
        @(negedge clk);
        cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        idle(8);
        do_req(1, 1'b0, 4'hF, 10'h010, 32'h0, 1'b1, 32'h12345678);

        // Reset while waiting: pending write discarded, no ack, next request normal.
        do_req(1, 1'b1, 4'hF, 10'h020, 32'h0000AAAA, 1'b0, 32'h0);
        @(negedge clk);
        cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF;
        addr[1] = 10'h020; wdat[1] = 32'hCAFEF00D;
        idle(2);
        rst_n[1] = 1'b0; cyc[1] = 1'b0; stb[1] = 1'b0; we[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b1;
        idle(8);
        do_req(1, 1'b0, 4'hF, 10'h020, 32'h0, 1'b1, 32'h0000AAAA);

        // Randomized traffic, addresses clustered to get read-after-write hits.
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 120; k++) begin
                int r;
                logic [9:0] a;
                r = $urandom_range(0, 9);
                if (r == 0)      a = 10'($urandom_range(256, 1023));
                else if (r <= 2) a = 10'($urandom_range(248, 255));
                else             a = 10'($urandom_range(0, 15));
                do_req(d, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a,
                       $urandom, 1'b0, 32'h0);
            end
        end

        idle(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
